// File: rtl/maze_pkg.sv
// Shared types and helpers for the maze actor movement controller.
// Directions are one-hot {up,down,left,right}.
package maze_pkg;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    localparam int MAZE_W = 12;
    localparam int MAZE_H = 12;

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUERY,
        S_DECIDE
    } state_t;

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [3:0] opposite(input logic [3:0] d);
        case (d)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_LEFT:  return DIR_RIGHT;
            DIR_RIGHT: return DIR_LEFT;
            default:   return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/maze_mover_if.sv
// Wall-lookup query bus: tile coordinates out, open-exit mask back.
// The mover is the master; the wall checker is the slave.
interface maze_mover_if;
    logic [4:0] tile_x;
    logic [4:0] tile_y;
    logic [3:0] turnable;

    modport master (
        output tile_x,
        output tile_y,
        input  turnable
    );

    modport slave (
        input  tile_x,
        input  tile_y,
        output turnable
    );
endinterface

// File: rtl/maze_mover.sv
// One-pixel-per-frame sprite mover: queries walls at the current tile,
// decides turn/continue/stop at tile centres, and steps the actor.
module maze_mover
    import maze_pkg::*;
#(
    parameter int         TILE_PX   = 16,
    parameter logic [4:0] START_X   = 5'd7,
    parameter logic [4:0] START_Y   = 5'd9,
    parameter logic [3:0] START_DIR = 4'b0010
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                frame_tick,
    input  logic [3:0]          req_dir,
    maze_mover_if.master        wall,
    output logic [9:0]          pos_x,
    output logic [9:0]          pos_y,
    output logic [3:0]          cur_dir,
    output logic                moving,
    output logic                step_done
);

    localparam int SW = $clog2(TILE_PX);
    localparam logic [SW-1:0] SUB_MAX = SW'(TILE_PX - 1);
    localparam logic [SW-1:0] SUB_ONE = SW'(1);
    localparam logic [4:0]    MAX_X   = 5'(MAZE_W);
    localparam logic [4:0]    MAX_Y   = 5'(MAZE_H);

    state_t        state_q, state_n;
    logic [4:0]    tile_x_q, tile_y_q, tx_n, ty_n;
    logic [SW-1:0] sub_x_q, sub_y_q, sx_n, sy_n;
    logic [3:0]    dir_q, dir_n, dir_c;
    logic          moving_q;
    logic          centre, go, blocked, commit;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE:   if (frame_tick) state_n = S_QUERY;
            S_QUERY:  state_n = S_DECIDE;
            S_DECIDE: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_comb begin
        commit    = (state_q == S_DECIDE);
        step_done = commit;
    end

    assign centre = (sub_x_q == '0) && (sub_y_q == '0);

    always_comb begin
        dir_n   = dir_q;
        dir_c   = dir_q;
        go      = 1'b0;
        blocked = 1'b0;
        if (centre) begin
            if (is_onehot(req_dir) && |(req_dir & wall.turnable)) begin
                dir_c = req_dir;
                go    = 1'b1;
            end else if (|(dir_q & wall.turnable)) begin
                go    = 1'b1;
            end
            // Outside the maze the checker reports all exits open
            blocked = (dir_c == DIR_LEFT  && tile_x_q == 5'd1)
                   || (dir_c == DIR_RIGHT && tile_x_q == MAX_X)
                   || (dir_c == DIR_UP    && tile_y_q == 5'd1)
                   || (dir_c == DIR_DOWN  && tile_y_q == MAX_Y);
            if (blocked) go = 1'b0;
            if (go)      dir_n = dir_c;
        end else begin
            go = 1'b1;
            if (req_dir == opposite(dir_q)) dir_n = req_dir;
        end
    end

    always_comb begin
        tx_n = tile_x_q;
        ty_n = tile_y_q;
        sx_n = sub_x_q;
        sy_n = sub_y_q;
        if (go) begin
            unique case (1'b1)
                dir_n[0]: begin
                    if (sub_x_q == SUB_MAX) begin
                        sx_n = '0;
                        tx_n = tile_x_q + 5'd1;
                    end else begin
                        sx_n = sub_x_q + SUB_ONE;
                    end
                end
                dir_n[1]: begin
                    if (sub_x_q == '0) begin
                        sx_n = SUB_MAX;
                        tx_n = tile_x_q - 5'd1;
                    end else begin
                        sx_n = sub_x_q - SUB_ONE;
                    end
                end
                dir_n[2]: begin
                    if (sub_y_q == SUB_MAX) begin
                        sy_n = '0;
                        ty_n = tile_y_q + 5'd1;
                    end else begin
                        sy_n = sub_y_q + SUB_ONE;
                    end
                end
                dir_n[3]: begin
                    if (sub_y_q == '0) begin
                        sy_n = SUB_MAX;
                        ty_n = tile_y_q - 5'd1;
                    end else begin
                        sy_n = sub_y_q - SUB_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            tile_x_q <= START_X;
            tile_y_q <= START_Y;
            sub_x_q  <= '0;
            sub_y_q  <= '0;
            dir_q    <= START_DIR;
            moving_q <= 1'b0;
        end else if (commit) begin
            tile_x_q <= tx_n;
            tile_y_q <= ty_n;
            sub_x_q  <= sx_n;
            sub_y_q  <= sy_n;
            dir_q    <= dir_n;
            moving_q <= go;
        end
    end

    assign wall.tile_x = tile_x_q;
    assign wall.tile_y = tile_y_q;
    assign cur_dir     = dir_q;
    assign moving      = moving_q;

    assign pos_x = 10'((10'(tile_x_q) - 10'd1) * 10'(TILE_PX)) + 10'(sub_x_q);
    assign pos_y = 10'((10'(tile_y_q) - 10'd1) * 10'(TILE_PX)) + 10'(sub_y_q);

endmodule
